// File: rtl/parity_frame_tx.sv
// Serial line driver for the parity path: start, d0..d3 LSB-first,
// parity, stop. Upstream parity bits are checked, never transmitted.
module parity_frame_tx #(
    parameter int CLKS_PER_BIT = 4,
    parameter bit ODD_PARITY   = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] data_in,
    input  logic       even_priority,
    input  logic       odd_priority,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       tx_out,
    output logic       busy,
    output logic       par_err
);

    localparam int DW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t        state;
    logic [DW-1:0] div;
    logic [1:0]    idx;
    logic [3:0]    data_q;
    logic          par_q;
    logic          bit_done;
    logic          local_par;
    logic          up_bad;

    assign in_ready  = (state == IDLE) && !rst;
    assign bit_done  = (div == DIV_LAST);
    assign local_par = ^data_in;
    assign up_bad    = (even_priority != local_par) ||
                       (odd_priority == even_priority);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            div     <= '0;
            idx     <= '0;
            data_q  <= '0;
            par_q   <= 1'b0;
            tx_out  <= 1'b1;
            busy    <= 1'b0;
            par_err <= 1'b0;
        end else begin
            par_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        data_q  <= data_in;
                        par_q   <= local_par ^ ODD_PARITY;
                        par_err <= up_bad;
                        state   <= START;
                        div     <= '0;
                        idx     <= '0;
                        tx_out  <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                START: begin
                    if (bit_done) begin
                        div    <= '0;
                        idx    <= '0;
                        state  <= DATA;
                        tx_out <= data_q[0];
                    end else begin
                        div <= div + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        div <= '0;
                        if (idx == 2'd3) begin
                            state  <= PARITY;
                            tx_out <= par_q;
                        end else begin
                            idx    <= idx + 2'd1;
                            tx_out <= data_q[idx + 2'd1];
                        end
                    end else begin
                        div <= div + 1'b1;
                    end
                end
                PARITY: begin
                    if (bit_done) begin
                        div    <= '0;
                        state  <= STOP;
                        tx_out <= 1'b1;
                    end else begin
                        div <= div + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        div   <= '0;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        div <= div + 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    div    <= '0;
                    tx_out <= 1'b1;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule
